// File: rtl/sopc_cpu_div_pkg.sv
// Shared types and helpers for the iterative restoring divider cell.
package sopc_cpu_div_pkg;

  localparam int DIV_WIDTH = 32;
  // Helpers work on the widest supported operand; callers truncate to their width.
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } div_state_e;

  function automatic logic [MAX_WIDTH-1:0] div_negate(input logic [MAX_WIDTH-1:0] value);
    return ~value + MAX_WIDTH'(1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] div_abs(input logic [MAX_WIDTH-1:0] value,
                                                   input logic is_neg);
    if (is_neg) begin
      return div_negate(value);
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/sopc_cpu_div_if.sv
// Request/result bundle between the pipeline and the divider cell.
interface sopc_cpu_div_if
  import sopc_cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, src1, src2,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, src1, src2,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/sopc_cpu_div_step.sv
// One restoring-division iteration: shift {rem, dvd} left and try subtracting the divisor.
module sopc_cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next,
  output logic             q_bit
);
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] trial_s;

  // The shifted remainder needs WIDTH+1 bits; the extra top bit of trial is the borrow.
  always_comb begin
    shifted_s = {rem, dvd[WIDTH-1]};
    trial_s   = {1'b0, shifted_s} - {2'b00, divisor};
    q_bit     = ~trial_s[WIDTH+1];
    if (q_bit) begin
      rem_next = WIDTH'(trial_s);
    end else begin
      rem_next = WIDTH'(shifted_s);
    end
    // Vacated LSB is filled with the quotient bit by the caller.
    dvd_next = {dvd[WIDTH-2:0], 1'b0};
  end
endmodule

// File: rtl/sopc_cpu_div_cell.sv
// Iterative signed/unsigned restoring divider: one quotient bit per clock, results held until next start.
module sopc_cpu_div_cell
  import sopc_cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          reset_n,
  sopc_cpu_div_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic             sop_r, sop_nx_s;
  logic [WIDTH-1:0] src1_r, src1_nx_s;
  logic [WIDTH-1:0] src2_r, src2_nx_s;
  logic             q_neg_r, q_neg_nx_s;
  logic             r_neg_r, r_neg_nx_s;
  logic             dz_r, dz_nx_s;
  logic [WIDTH-1:0] rem_r, rem_nx_s;
  logic [WIDTH-1:0] dvd_r, dvd_nx_s;
  logic [WIDTH-1:0] dsr_r, dsr_nx_s;
  logic             busy_r, busy_nx_s;
  logic             done_r, done_nx_s;
  logic [WIDTH-1:0] quot_r, quot_nx_s;
  logic [WIDTH-1:0] remd_r, remd_nx_s;
  logic             dz_out_r, dz_out_nx_s;

  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_dvd_s;
  logic             step_q_s;

  sopc_cpu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .dvd      (dvd_r),
    .divisor  (dsr_r),
    .rem_next (step_rem_s),
    .dvd_next (step_dvd_s),
    .q_bit    (step_q_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nx_s = PREP;
        end else begin
          state_nx_s = IDLE;
        end
      end
      PREP: state_nx_s = ITER;
      ITER: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nx_s = FIX;
        end else begin
          state_nx_s = ITER;
        end
      end
      FIX:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath and output next values per state.
  always_comb begin
    cnt_nx_s    = cnt_r;
    sop_nx_s    = sop_r;
    src1_nx_s   = src1_r;
    src2_nx_s   = src2_r;
    q_neg_nx_s  = q_neg_r;
    r_neg_nx_s  = r_neg_r;
    dz_nx_s     = dz_r;
    rem_nx_s    = rem_r;
    dvd_nx_s    = dvd_r;
    dsr_nx_s    = dsr_r;
    busy_nx_s   = busy_r;
    done_nx_s   = 1'b0;
    quot_nx_s   = quot_r;
    remd_nx_s   = remd_r;
    dz_out_nx_s = dz_out_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          sop_nx_s  = bus.signed_op;
          src1_nx_s = bus.src1;
          src2_nx_s = bus.src2;
          busy_nx_s = 1'b1;
        end else begin
          busy_nx_s = 1'b0;
        end
      end
      PREP: begin
        q_neg_nx_s = sop_r & (src1_r[WIDTH-1] ^ src2_r[WIDTH-1]);
        r_neg_nx_s = sop_r & src1_r[WIDTH-1];
        dz_nx_s    = (src2_r == {WIDTH{1'b0}});
        dvd_nx_s   = WIDTH'(div_abs(MAX_WIDTH'(src1_r), sop_r & src1_r[WIDTH-1]));
        dsr_nx_s   = WIDTH'(div_abs(MAX_WIDTH'(src2_r), sop_r & src2_r[WIDTH-1]));
        rem_nx_s   = {WIDTH{1'b0}};
        cnt_nx_s   = CNT_W'(WIDTH - 1);
      end
      ITER: begin
        rem_nx_s = step_rem_s;
        dvd_nx_s = step_dvd_s | WIDTH'(step_q_s);
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_nx_s = cnt_r - CNT_W'(1);
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      FIX: begin
        busy_nx_s   = 1'b0;
        done_nx_s   = 1'b1;
        dz_out_nx_s = dz_r;
        // Divide-by-zero overrides the signed fix-up and returns the raw dividend.
        if (dz_r) begin
          quot_nx_s = {WIDTH{1'b1}};
          remd_nx_s = src1_r;
        end else begin
          quot_nx_s = WIDTH'(div_abs(MAX_WIDTH'(dvd_r), q_neg_r));
          remd_nx_s = WIDTH'(div_abs(MAX_WIDTH'(rem_r), r_neg_r));
        end
      end
      default: begin
        busy_nx_s = 1'b0;
      end
    endcase
  end

  // Operand, iteration and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      sop_r    <= 1'b0;
      src1_r   <= {WIDTH{1'b0}};
      src2_r   <= {WIDTH{1'b0}};
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      dz_r     <= 1'b0;
      rem_r    <= {WIDTH{1'b0}};
      dvd_r    <= {WIDTH{1'b0}};
      dsr_r    <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      quot_r   <= {WIDTH{1'b0}};
      remd_r   <= {WIDTH{1'b0}};
      dz_out_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nx_s;
      sop_r    <= sop_nx_s;
      src1_r   <= src1_nx_s;
      src2_r   <= src2_nx_s;
      q_neg_r  <= q_neg_nx_s;
      r_neg_r  <= r_neg_nx_s;
      dz_r     <= dz_nx_s;
      rem_r    <= rem_nx_s;
      dvd_r    <= dvd_nx_s;
      dsr_r    <= dsr_nx_s;
      busy_r   <= busy_nx_s;
      done_r   <= done_nx_s;
      quot_r   <= quot_nx_s;
      remd_r   <= remd_nx_s;
      dz_out_r <= dz_out_nx_s;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = remd_r;
  assign bus.div_by_zero = dz_out_r;

endmodule

// File: tb/tb_sopc_cpu_div_cell.sv
// Directed bench for sopc_cpu_div_cell: latency, signed/unsigned results, divide-by-zero, ignored start, reset.
module tb_sopc_cpu_div_cell;
  import sopc_cpu_div_pkg::*;

  logic clk;
  logic reset_n;
  int   total;
  int   passed;
  int   lat;
  int   seen;

  sopc_cpu_div_if #(.WIDTH(32)) bus ();

  sopc_cpu_div_cell #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one start pulse; returns just after the accepting edge.
  task automatic launch(input logic op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = op;
    bus.src1      = a;
    bus.src2      = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  // Count edges since acceptance until done; bounded, -1 on timeout.
  task automatic wait_done(input int already, output int latency);
    int ovl;
    ovl     = 0;
    latency = -1;
    for (int n = already + 1; n <= already + 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.busy && bus.done) ovl = 1;
      if (bus.done) begin
        latency = n;
        break;
      end
    end
    chk("busy_done_overlap", 32'(ovl), 32'd0);
  endtask

  task automatic run(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int l;
    launch(op, a, b);
    wait_done(0, l);
    chk({tag, "_latency"}, 32'(l), 32'd34);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_dz"}, 32'(bus.div_by_zero), 32'(edz));
  endtask

  initial begin
    total         = 0;
    passed        = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.src1      = 32'd0;
    bus.src2      = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q", bus.quotient, 32'd0);
    chk("rst_r", bus.remainder, 32'd0);
    @(negedge clk) reset_n = 1'b1;

    run("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    // Results stay put and done is a single pulse.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", 32'(bus.done), 32'd0);
    chk("hold_q", bus.quotient, 32'd14);
    chk("hold_r", bus.remainder, 32'd2);

    run("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    run("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run("s_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
    run("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run("s_min_1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
    run("u_dz", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run("s_dz", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run("s_dzneg", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    run("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Start while busy is ignored.
    launch(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.signed_op = 1'b1;
    bus.src1      = 32'd1000;
    bus.src2      = 32'd10;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(10, lat);
    chk("ign_latency", 32'(lat), 32'd34);
    chk("ign_q", bus.quotient, 32'd14);
    chk("ign_r", bus.remainder, 32'd2);

    // Start during the done cycle is accepted.
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.src1      = 32'd1000;
    bus.src2      = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    chk("b2b_done", 32'(bus.done), 32'd0);
    wait_done(0, lat);
    chk("b2b_latency", 32'(lat), 32'd34);
    chk("b2b_q", bus.quotient, 32'd333);
    chk("b2b_r", bus.remainder, 32'd1);

    // Asynchronous reset in the middle of ITER.
    launch(1'b0, 32'd5, 32'd0);
    wait_done(0, lat);
    chk("pre_rst_dz", 32'(bus.div_by_zero), 32'd1);
    launch(1'b0, 32'h1234_5678, 32'h0000_0011);
    repeat (11) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_dz", 32'(bus.div_by_zero), 32'd0);
    chk("arst_q", bus.quotient, 32'd0);
    chk("arst_r", bus.remainder, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen = 1;
    end
    chk("discarded_op", 32'(seen), 32'd0);
    run("post_rst", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sopc_cpu_div_cell.md
# sopc_cpu_div_cell

Iterative integer divider cell for the soft CPU execute/memory pipeline; the inverse arithmetic companion of the pipelined multiplier cell. It accepts a dividend/divisor pair on a one-cycle start strobe and computes quotient and remainder by restoring radix-2 division, one bit per clock. It supports signed and unsigned operation and reports a one-cycle done pulse, with results held until the next start.

## Interface
- WIDTH, 32, operand/result width in bits (≥4).
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- signed_op  in  1  1 = two's-complement DIV, 0 = DIVU; sampled with start.
- src1  in  WIDTH  dividend; sampled with start.
- src2  in  WIDTH  divisor; sampled with start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse; quotient/remainder/div_by_zero valid from this cycle.
- quotient  out  WIDTH  result quotient, held until next accepted start.
- remainder  out  WIDTH  result remainder, held until next accepted start.
- div_by_zero  out  1  src2 was 0 for the completed operation; held with results.

## Operation
- FSM states: IDLE, PREP, ITER, FIX.
- IDLE: start=1 latches signed_op, src1, src2 → PREP. start is ignored in every other state.
- PREP:
  - Compute magnitudes (abs when signed_op, raw otherwise).
  - Record q_neg = signed_op & (src1[MSB] ^ src2[MSB]) and r_neg = signed_op & src1[MSB].
  - Load the shift register with |src1|; clear the partial remainder; count := WIDTH-1 → ITER.
- ITER:
  - Per cycle, shift {rem, dvd} left 1.
  - trial = rem − |src2| in WIDTH+1 bits.
  - If trial ≥ 0: rem := trial and the quotient LSB is 1; otherwise 0.
  - At count==0 → FIX; otherwise count−1.
- FIX: apply sign (negate quotient if q_neg, remainder if r_neg), register outputs, done:=1 → IDLE.
- Magnitudes are handled as WIDTH-bit unsigned values: abs(−2^(WIDTH−1)) = 2^(WIDTH−1) is exact.
- Signed overflow (−2^(WIDTH−1) / −1) yields quotient 0x8000_0000 and remainder 0 with no flag.
- Remainder sign follows the dividend (truncating division).
- Divisor 0:
  - Latency is unchanged.
  - Results are forced to quotient = all ones and remainder = src1 (unmodified), with div_by_zero=1, regardless of signed_op.
- Reset (any time, including mid-ITER):
  - State → IDLE.
  - busy, done, div_by_zero → 0; quotient, remainder → 0.
  - The in-flight operation is discarded.

## Timing
- Edge E0 samples start=1 in IDLE; busy=1 after E0.
- E1: PREP→ITER. E2..E(WIDTH+1): WIDTH iterations. E(WIDTH+2): FIX registers results.
- done=1 and busy=0 for exactly the cycle after E(WIDTH+2). For WIDTH=32 that is 34 edges after start.
- Outputs change only at the FIX edge (or reset); they are stable otherwise.
- A start asserted during the done cycle is accepted (state is IDLE); back-to-back throughput is one result per WIDTH+3 cycles.
- done never asserts without a preceding accepted start; busy and done are never high together.

## Structure
- Shared package sopc_cpu_div_pkg: state enum (IDLE, PREP, ITER, FIX), default WIDTH constant, abs/negate functions.
- One sub-module: sopc_cpu_div_step. It is the combinational single restoring iteration: inputs rem, dvd, divisor; outputs next rem, next dvd, quotient bit.
- The top holds the FSM, counter (clog2(WIDTH) bits), operand/sign registers and output registers.

## Test plan
- Unsigned 100/7, signed_op=0 → done exactly 34 cycles after start; quotient=14, remainder=2, div_by_zero=0.
- Signed −7/2 (0xFFFFFFF9 / 2), signed_op=1 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; unsigned run of the same operands → quotient=0x7FFFFFFC, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0; signed 0x80000000/1 → quotient=0x80000000, remainder=0.
- Divide by zero 5/0 (both modes) → quotient=0xFFFFFFFF, remainder=5, div_by_zero=1 at cycle 34; the next 9/3 clears the flag, giving quotient=3, remainder=0.
- Start pulsed at cycle 10 while busy → ignored, first result unchanged. Start in the done cycle → accepted, second done 34 cycles later.
- reset_n low at ITER cycle 10 → busy, done, div_by_zero, quotient, remainder all 0 asynchronously. After release, 1000/10 completes normally: quotient=100, remainder=0.
